// File: rtl/pending_priority_encoder_16x4_pkg.sv
// Shared constants and state encoding for the 16-line pending priority encoder.
// Also holds a one-hot helper used to clear the serviced pending bit.
package pending_priority_encoder_16x4_pkg;

  localparam int N_IN  = 16;
  localparam int IDX_W = 4;

  // FSM state encoding
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] VALID = 1'b1;

  function automatic logic [N_IN-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_IN-1:0] one;
    one = {{(N_IN-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/pending_priority_encoder_16x4_enc.sv
// Combinational lowest-set-bit encoder: bit 0 has the highest priority.
// idx is 0 whenever no bit is set.
module priority_encoder_16x4
  import pending_priority_encoder_16x4_pkg::*;
(
  input  logic [N_IN-1:0]  vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    // Scan downward so the lowest set bit is the last (winning) assignment.
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    any = |vec;
  end

endmodule

// File: rtl/pending_priority_encoder_16x4.sv
// Sticky pending register plus IDLE/VALID handshake FSM; emits the lowest pending
// index with valid/ready and clears the serviced bit when it is loaded.
module pending_priority_encoder_16x4
  import pending_priority_encoder_16x4_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_IN-1:0]  req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_index,
  output logic [N_IN-1:0]  pending,
  output logic             overflow
);

  // state | meaning
  // IDLE  | no index presented; loads ffs(pending) when anything is pending
  // VALID | out_index presented; advances on out_ready (back-to-back if more pending)
  logic [0:0]       state;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             load;
  logic [N_IN-1:0]  set_mask;
  logic [N_IN-1:0]  clr_mask;
  logic [N_IN-1:0]  pending_next;
  logic             overflow_next;

  priority_encoder_16x4 u_enc (
    .vec (pending),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_comb begin
    set_mask = req & {N_IN{enable}};
    load     = 1'b0;
    case (state)
      IDLE:    load = enc_any;
      VALID:   load = out_ready & enc_any;
      default: load = 1'b0;
    endcase
    clr_mask      = load ? idx_to_onehot(enc_idx) : '0;
    // Set wins over clear: a re-request of the loaded bit keeps it pending.
    pending_next  = (pending & ~clr_mask) | set_mask;
    overflow_next = |(set_mask & pending & ~clr_mask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      overflow  <= 1'b0;
    end else begin
      pending  <= pending_next;
      overflow <= overflow_next;
      case (state)
        IDLE: begin
          if (enc_any) begin
            out_index <= enc_idx;
            out_valid <= 1'b1;
            state     <= VALID;
          end
        end
        VALID: begin
          if (out_ready) begin
            if (enc_any) begin
              out_index <= enc_idx;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pending_priority_encoder_16x4.sv
// Directed bench for pending_priority_encoder_16x4 with hand-computed expectations.
module tb_pending_priority_encoder_16x4;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] req;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_index;
  logic [15:0] pending;
  logic        overflow;

  int tests_run = 0;
  int tests_failed = 0;

  pending_priority_encoder_16x4 dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_index (out_index),
    .pending   (pending),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; req = 16'h0000; out_ready = 1'b1;
    #2;
    tests_run++;
    if ({out_valid, out_index, pending, overflow} !== 22'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got valid=%0b idx=%0h pend=%h ovf=%0b, want all zero",
               out_valid, out_index, pending, overflow);
    end
    #1 reset = 1'b0;
    tick();
  endtask

  task automatic test_single_high();
    req = 16'h8000;
    tick();
    req = 16'h0000;
    tests_run++;
    if (pending !== 16'h8000 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_capture: got pend=%h valid=%0b, want pend=8000 valid=0", pending, out_valid);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_index !== 4'hF || pending !== 16'h0000) begin
      tests_failed++;
      $display("FAIL single_load: got valid=%0b idx=%0h pend=%h, want valid=1 idx=f pend=0000",
               out_valid, out_index, pending);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_drain: got valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_idx [3];
    exp_idx[0] = 4'd0; exp_idx[1] = 4'd5; exp_idx[2] = 4'd10;
    req = 16'h0421;
    tick();
    req = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_index !== exp_idx[i]) begin
        tests_failed++;
        $display("FAIL b2b_idx%0d: got valid=%0b idx=%0d, want valid=1 idx=%0d",
                 i, out_valid, out_index, exp_idx[i]);
      end
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: got valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    req = 16'h0006;
    tick();
    req = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_index !== 4'd1 || pending !== 16'h0004) begin
        tests_failed++;
        $display("FAIL hold_cyc%0d: got valid=%0b idx=%0d pend=%h, want valid=1 idx=1 pend=0004",
                 i, out_valid, out_index, pending);
      end
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_index !== 4'd2 || pending !== 16'h0000) begin
      tests_failed++;
      $display("FAIL hold_release: got valid=%0b idx=%0d pend=%h, want valid=1 idx=2 pend=0000",
               out_valid, out_index, pending);
    end
    tick();
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    req = 16'h0008;
    tick();
    req = 16'h0000;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_index !== 4'd3 || pending !== 16'h0000) begin
      tests_failed++;
      $display("FAIL ovf_setup: got valid=%0b idx=%0d pend=%h, want valid=1 idx=3 pend=0000",
               out_valid, out_index, pending);
    end
    req = 16'h0009;
    tick();
    req = 16'h0000;
    tests_run++;
    if (pending !== 16'h0009 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_first: got pend=%h ovf=%0b, want pend=0009 ovf=0", pending, overflow);
    end
    req = 16'h0008;
    tick();
    req = 16'h0000;
    tests_run++;
    if (overflow !== 1'b1 || pending !== 16'h0009 || out_index !== 4'd3) begin
      tests_failed++;
      $display("FAIL ovf_pulse: got ovf=%0b pend=%h idx=%0d, want ovf=1 pend=0009 idx=3",
               overflow, pending, out_index);
    end
    tick();
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_one_cycle: got ovf=%0b, want 0", overflow);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_index !== 4'd0 || pending !== 16'h0008) begin
      tests_failed++;
      $display("FAIL ovf_drain0: got idx=%0d pend=%h, want idx=0 pend=0008", out_index, pending);
    end
    tick();
    tests_run++;
    if (out_index !== 4'd3 || out_valid !== 1'b1 || pending !== 16'h0000) begin
      tests_failed++;
      $display("FAIL ovf_drain3: got valid=%0b idx=%0d pend=%h, want valid=1 idx=3 pend=0000",
               out_valid, out_index, pending);
    end
    tick();
    tick();
  endtask

  task automatic test_set_wins();
    out_ready = 1'b1;
    req = 16'h0001;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_index !== 4'd0 || pending !== 16'h0001 || overflow !== 1'b0) begin
        tests_failed++;
        $display("FAIL set_wins%0d: got valid=%0b idx=%0d pend=%h ovf=%0b, want 1/0/0001/0",
                 i, out_valid, out_index, pending, overflow);
      end
    end
    req = 16'h0000;
    tick();
    tick();
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || pending !== 16'h0000) begin
      tests_failed++;
      $display("FAIL set_wins_end: got valid=%0b pend=%h, want valid=0 pend=0000", out_valid, pending);
    end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    req = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (pending !== 16'h0000 || out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL en_block%0d: got pend=%h valid=%0b, want pend=0000 valid=0", i, pending, out_valid);
      end
    end
    enable = 1'b1;
    tick();
    req = 16'h0000;
    tests_run++;
    if (pending !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL en_capture: got pend=%h, want ffff", pending);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_index !== 4'(i)) begin
        tests_failed++;
        $display("FAIL en_drain%0d: got valid=%0b idx=%0d, want valid=1 idx=%0d", i, out_valid, out_index, i);
      end
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || pending !== 16'h0000) begin
      tests_failed++;
      $display("FAIL en_done: got valid=%0b pend=%h, want valid=0 pend=0000", out_valid, pending);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    req = 16'h0030;
    tick();
    req = 16'h0000;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_index !== 4'd4 || pending !== 16'h0020) begin
      tests_failed++;
      $display("FAIL mid_setup: got valid=%0b idx=%0d pend=%h, want valid=1 idx=4 pend=0020",
               out_valid, out_index, pending);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({out_valid, out_index, pending, overflow} !== 22'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: got valid=%0b idx=%0h pend=%h ovf=%0b, want all zero",
               out_valid, out_index, pending, overflow);
    end
    #1 reset = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || pending !== 16'h0000) begin
      tests_failed++;
      $display("FAIL mid_after: got valid=%0b pend=%h, want valid=0 pend=0000", out_valid, pending);
    end
  endtask

  initial begin
    test_reset();
    test_single_high();
    test_back_to_back();
    test_hold();
    test_overflow();
    test_set_wins();
    test_enable();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
